// File: rtl/fifo_ctrl.sv
// fifo_ctrl: storage and control stage of an 8-entry FIFO.
// Classifies each request into an operation state, holds the data words,
// and advances head/tail pointers and the occupancy count.
// Optional feature: define FIFO_DOUT_CLR_EN to zero dout on every non-READ edge.
module fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [2:0]            state,
   output logic [3:0]            data_count
);

   localparam int unsigned PTR_W = 3;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      WRITE    = 3'b001,
      READ     = 3'b010,
      WR_ERROR = 3'b011,
      RD_ERROR = 3'b100
   } op_state_t;

   op_state_t             state_q;
   op_state_t             state_d;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign state      = state_q;
   assign data_count = count;

   // Operation state register; reset forces IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Classify this cycle's request against the current occupancy.
   always_comb begin
      state_d = IDLE;
      if (wr_en && !rd_en) begin
         state_d = (count == FULL_CNT) ? WR_ERROR : WRITE;
      end else if (!wr_en && rd_en) begin
         state_d = (count == '0) ? RD_ERROR : READ;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         case (state_d)
            WRITE: begin
               tail  <= tail + PTR_W'(1);
               count <= count + CNT_W'(1);
            end
            READ: begin
               head  <= head + PTR_W'(1);
               count <= count - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (state_d == WRITE) begin
         mem[tail] <= din;
      end
   end

   // Registered read data, valid in the cycle state shows READ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
      end else if (state_d == READ) begin
         dout <= mem[head];
      end else begin
`ifdef FIFO_DOUT_CLR_EN
         dout <= '0;
`else
         dout <= dout;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl (honours FIFO_DOUT_CLR_EN).
module tb_fifo_ctrl;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic [2:0]    state;
   logic [3:0]    data_count;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [2:0]    st;
      logic [3:0]    cnt;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sb [$];
   logic [DW-1:0] mq [$];
   logic [DW-1:0] m_dout;

   fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .din        (din),
      .dout       (dout),
      .state      (state),
      .data_count (data_count)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one request, push the model's expectation, pop and compare after the edge.
   task automatic op(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
      exp_t e;
      exp_t g;
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      din   = d;
      if (w && !r) begin
         if (mq.size() < 8) begin
            mq.push_back(d);
            e.st = 3'b001;
         end else begin
            e.st = 3'b011;
         end
      end else if (!w && r) begin
         if (mq.size() > 0) begin
            m_dout = mq.pop_front();
            e.st   = 3'b010;
         end else begin
            e.st = 3'b100;
         end
      end else begin
         e.st = 3'b000;
      end
`ifdef FIFO_DOUT_CLR_EN
      if (e.st != 3'b010) m_dout = '0;
`endif
      e.cnt = 4'(mq.size());
      e.d   = m_dout;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check({tag, ".state"}, DW'(state), DW'(g.st));
      check({tag, ".count"}, DW'(data_count), DW'(g.cnt));
      check({tag, ".dout"}, dout, g.d);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".state"}, DW'(state), '0);
      check({tag, ".count"}, DW'(data_count), '0);
      check({tag, ".dout"}, dout, '0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
   endtask

   // Hard bound on simulation time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      model_reset();
      #12;
      check_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;

      // Asynchronous reset mid-cycle clears dout/state/count without an edge.
      op("w5a", 1'b1, 1'b0, 32'h5A);
      op("r5a", 1'b0, 1'b1, 32'h0);
      op("w77", 1'b1, 1'b0, 32'h77);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Fill, then overflow.
      for (int i = 1; i <= 8; i++) op("fill", 1'b1, 1'b0, DW'(i * 32'h11));
      op("ovf", 1'b1, 1'b0, 32'h99);

      // Drain in order, then underflow.
      for (int i = 0; i < 8; i++) op("drain", 1'b0, 1'b1, 32'h0);
      op("udf", 1'b0, 1'b1, 32'h0);
      op("idle", 1'b0, 1'b0, 32'h0);

      // Simultaneous request is rejected without side effects.
      for (int i = 0; i < 3; i++) op("pre_sim", 1'b1, 1'b0, DW'(32'hC0 + i));
      op("simul", 1'b1, 1'b1, 32'hDEAD);
      for (int i = 0; i < 3; i++) op("post_sim", 1'b0, 1'b1, 32'h0);

      // Wrap-around across the pointer boundary.
      for (int i = 0; i < 6; i++) op("wrap_w6", 1'b1, 1'b0, DW'(32'hB0 + i));
      for (int i = 0; i < 6; i++) op("wrap_r6", 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 5; i++) op("wrap_w5", 1'b1, 1'b0, DW'(32'hA0 + i));
      op("wrap_idle", 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) op("wrap_r5", 1'b0, 1'b1, 32'h0);

      // Reset during the fifth write of a fill.
      for (int i = 0; i < 4; i++) op("mid_fill", 1'b1, 1'b0, DW'(32'hE0 + i));
      @(negedge clk);
      wr_en = 1'b1;
      rd_en = 1'b0;
      din   = 32'hE4;
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("rst_fill");
      @(posedge clk);
      #1;
      check_reset_vals("rst_fill_edge");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      wr_en = 1'b0;
      op("rd_after_rst", 1'b0, 1'b1, 32'h0);
      op("wr_after_rst", 1'b1, 1'b0, 32'h3C);
      op("rd_after_wr", 1'b0, 1'b1, 32'h0);

      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: got %0d expected 0 leftover entries", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
